// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster timing constants and the delayed control bundle
// (hs/vs/blank) that travels alongside the mapper's ROM and RGB pipeline.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE   = 640;
    localparam int DEF_H_FP       = 16;
    localparam int DEF_H_SYNC     = 96;
    localparam int DEF_H_BP       = 48;
    localparam int DEF_V_ACTIVE   = 480;
    localparam int DEF_V_FP       = 10;
    localparam int DEF_V_SYNC     = 2;
    localparam int DEF_V_BP       = 33;
    localparam int DEF_PIPE_DELAY = 2;

    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int DEF_HS_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
    localparam int DEF_VS_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

    // Counters are 10 bits wide, so neither total may exceed this.
    localparam int MAX_TOTAL = 1024;

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank;
    } vga_ctl_t;

    localparam vga_ctl_t VGA_CTL_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b0};

    function automatic logic in_window(input logic [10:0] cnt, input int lo, input int hi);
        return (cnt >= 11'(lo)) && (cnt < 11'(hi));
    endfunction

endpackage

// File: rtl/vga_timing_gen_delay.sv
// N-stage shift register for the hs/vs/blank bundle; N=0 is a plain wire.
// Reset fills every stage with the idle (no sync, blanked) pattern.
module vga_ctl_delay
    import vga_timing_pkg::*;
#(
    parameter int N = 2
) (
    input  logic     vga_clk,
    input  logic     reset_n,
    input  vga_ctl_t d,
    output vga_ctl_t q
);

    if (N == 0) begin : g_pass
        assign q = d;
    end else begin : g_pipe
        vga_ctl_t stage_p [N];

        always_ff @(posedge vga_clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i < N; i++) stage_p[i] <= VGA_CTL_IDLE;
            end else begin
                stage_p[0] <= d;
                for (int i = 1; i < N; i++) stage_p[i] <= stage_p[i-1];
            end
        end

        assign q = stage_p[N-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters and sync/blank decode. DrawX/DrawY feed the tile mapper
// undelayed; hs/vs/blank are delayed to line up with the mapper's RGB output.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int PIPE_DELAY = DEF_PIPE_DELAY
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    output logic        hs,
    output logic        vs,
    output logic        blank,
    output logic        sync,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL=%0d / V_TOTAL=%0d exceed 1024", H_TOTAL, V_TOTAL);
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_delay
        $error("vga_timing_gen: PIPE_DELAY=%0d outside 0..7", PIPE_DELAY);
    end

    logic [9:0]  hc;
    logic [9:0]  vc;
    logic        h_last;
    logic        v_last;
    logic [10:0] hc_w;
    logic [10:0] vc_w;
    vga_ctl_t    ctl_raw;
    vga_ctl_t    ctl_dly;

    assign h_last = (hc == 10'(H_TOTAL - 1));
    assign v_last = (vc == 10'(V_TOTAL - 1));

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hc          <= '0;
            vc          <= '0;
            frame_count <= '0;
        end else begin
            hc <= h_last ? 10'd0 : hc + 10'd1;
            if (h_last) begin
                vc <= v_last ? 10'd0 : vc + 10'd1;
                if (v_last) frame_count <= frame_count + 16'd1;
            end
        end
    end

    // Widened by one bit so a window ending exactly at 1024 still compares correctly.
    assign hc_w = {1'b0, hc};
    assign vc_w = {1'b0, vc};

    always_comb begin
        ctl_raw       = VGA_CTL_IDLE;
        ctl_raw.blank = (hc_w < 11'(H_ACTIVE)) && (vc_w < 11'(V_ACTIVE));
        ctl_raw.hs    = !in_window(hc_w, HS_START, HS_END);
        ctl_raw.vs    = !in_window(vc_w, VS_START, VS_END);
    end

    vga_ctl_delay #(
        .N (PIPE_DELAY)
    ) u_ctl_delay (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .d       (ctl_raw),
        .q       (ctl_dly)
    );

    assign hs          = ctl_dly.hs;
    assign vs          = ctl_dly.vs;
    assign blank       = ctl_dly.blank;
    assign sync        = 1'b0;
    assign DrawX       = hc;
    assign DrawY       = vc;
    assign frame_start = (hc == 10'd0) && (vc == 10'd0);

endmodule
